irq_clint: RTL and testbench

- Core-local interrupt/exception sequencer. It sits directly upstream of the CSR register file and drives its clint write port (we/waddr/wdata).
- It consumes the CSR file's mtvec/mepc/mstatus/mie outputs.
- It detects ecall/ebreak/mret from execute and enabled timer/external interrupts. It stalls the pipeline, saves trap state into mepc/mstatus/mcause one CSR per cycle, then redirects fetch to mtvec (trap) or mepc (mret).

---
 rtl/irq_clint.sv | 158 +++++++++++++++
 tb/tb_irq_clint.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/irq_clint.sv
// Core-local trap sequencer: detects ecall/ebreak/mret and enabled timer/external
// interrupts, writes trap state into the CSR file one register per cycle, then redirects fetch.
module irq_clint #(
  parameter int TIMER_BIT = 0,
  parameter int EXT_BIT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  int_flag_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, TRAP_JMP, MRET_MSTATUS, MRET_JMP
  } state_t;

  typedef struct packed {
    logic        trap;
    logic        mret;
    logic [31:0] cause;
    logic [31:0] epc;
  } det_t;

  state_t      state;
  logic [31:0] cause_q;
  det_t        det;
  logic        timer_req, ext_req;
  logic [31:0] irq_epc;

  // Spare request lines and CSR bits outside MIE/MPIE/MTIE/MEIE are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, int_flag_i, mie_i, mtvec_i[1:0]};

  assign timer_req = int_flag_i[TIMER_BIT] & mie_i[7]  & mstatus_i[3];
  assign ext_req   = int_flag_i[EXT_BIT]   & mie_i[11] & mstatus_i[3];
  // Interrupts retire the execute instruction, so resume after it (or at its branch target).
  assign irq_epc   = jump_flag_i ? jump_addr_i : inst_addr_i + 32'd4;

  always_comb begin
    det = '0;
    if (state == IDLE && inst_valid_i) begin
      if (ecall_i) begin
        det.trap = 1'b1; det.cause = CAUSE_ECALL;  det.epc = inst_addr_i;
      end else if (ebreak_i) begin
        det.trap = 1'b1; det.cause = CAUSE_EBREAK; det.epc = inst_addr_i;
      end else if (mret_i) begin
        det.mret = 1'b1;
      end else if (timer_req) begin
        det.trap = 1'b1; det.cause = CAUSE_TIMER;  det.epc = irq_epc;
      end else if (ext_req) begin
        det.trap = 1'b1; det.cause = CAUSE_EXT;    det.epc = irq_epc;
      end
    end
  end

  assign stall_o = (state != IDLE) | det.trap | det.mret;

  function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Outputs are registered: each state's write/jump is set up on the edge entering it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cause_q      <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state)
        IDLE: begin
          if (det.trap) begin
            state       <= W_MEPC;
            cause_q     <= det.cause;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MEPC;
            csr_wdata_o <= det.epc;
          end else if (det.mret) begin
            state       <= MRET_MSTATUS;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MSTATUS;
            csr_wdata_o <= mstatus_mret(mstatus_i);
          end
        end
        W_MEPC: begin
          state       <= W_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MSTATUS;
          csr_wdata_o <= mstatus_trap(mstatus_i);
        end
        W_MSTATUS: begin
          state       <= W_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MCAUSE;
          csr_wdata_o <= cause_q;
        end
        W_MCAUSE: begin
          state        <= TRAP_JMP;
          int_assert_o <= 1'b1;
          int_addr_o   <= {mtvec_i[31:2], 2'b00};
        end
        MRET_MSTATUS: begin
          state        <= MRET_JMP;
          int_assert_o <= 1'b1;
          int_addr_o   <= mepc_i;
        end
        TRAP_JMP, MRET_JMP: state <= IDLE;
        default:            state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_clint.sv
// Directed bench for irq_clint: per-cycle expected outputs are queued as stimulus
// is driven and popped/compared on each falling edge.
module tb_irq_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  int_flag_i;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        ecall_i, ebreak_i, mret_i, jump_flag_i;
  logic [31:0] jump_addr_i, mtvec_i, mepc_i, mstatus_i, mie_i;
  logic        csr_we_o, stall_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

  irq_clint #(.TIMER_BIT(0), .EXT_BIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .int_flag_i(int_flag_i), .inst_valid_i(inst_valid_i),
    .inst_addr_i(inst_addr_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic stall, input logic we,
                      input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic ia, input logic [31:0] iaddr);
    exp_t e;
    e.tag = tag; e.stall = stall; e.we = we; e.waddr = waddr;
    e.wdata = wdata; e.ia = ia; e.iaddr = iaddr;
    q.push_back(e);
  endtask

  task automatic idle_exp(input string tag);
    push(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  // Compare the next queued expectation at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk(e.tag, "stall", {31'b0, stall_o},      {31'b0, e.stall});
      chk(e.tag, "we",    {31'b0, csr_we_o},     {31'b0, e.we});
      chk(e.tag, "waddr", csr_waddr_o,           e.waddr);
      chk(e.tag, "wdata", csr_wdata_o,           e.wdata);
      chk(e.tag, "ia",    {31'b0, int_assert_o}, {31'b0, e.ia});
      chk(e.tag, "iaddr", int_addr_o,            e.iaddr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_valid_i = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    jump_flag_i = 1'b0; int_flag_i = 8'h0;
  endtask

  // Expected trap sequence starting at the detecting cycle T.
  task automatic trap_exp(input string tag, input logic [31:0] epc, input logic [31:0] mst,
                          input logic [31:0] cause, input logic [31:0] vec);
    push({tag, "_T"},  1'b1, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0);
    push({tag, "_T1"}, 1'b1, 1'b1, 32'h341, epc,   1'b0, 32'h0);
    push({tag, "_T2"}, 1'b1, 1'b1, 32'h300, mst,   1'b0, 32'h0);
    push({tag, "_T3"}, 1'b1, 1'b1, 32'h342, cause, 1'b0, 32'h0);
    push({tag, "_T4"}, 1'b1, 1'b0, 32'h0,   32'h0, 1'b1, vec);
    idle_exp({tag, "_T5"});
  endtask

  initial begin
    rst_n = 1'b0; quiet();
    inst_addr_i = 32'h0; jump_addr_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0;
    mstatus_i = 32'h0; mie_i = 32'h0;

    // reset state
    idle_exp("reset"); tick();
    rst_n = 1'b1;
    idle_exp("post_reset"); tick();

    // timer interrupt, epc = pc+4
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h100; inst_addr_i = 32'h2000;
    int_flag_i = 8'h01; inst_valid_i = 1'b1;
    trap_exp("timer", 32'h2004, 32'h80, 32'h8000_0007, 32'h100);
    tick(); quiet();
    repeat (5) tick();

    // ecall with misaligned mtvec low bits masked off
    mstatus_i = 32'h88; mtvec_i = 32'h103; inst_addr_i = 32'h1234;
    inst_valid_i = 1'b1; ecall_i = 1'b1;
    trap_exp("ecall", 32'h1234, 32'h80, 32'd11, 32'h100);
    tick(); quiet();
    repeat (5) tick();

    // mret
    mstatus_i = 32'h80; mepc_i = 32'h3000; inst_valid_i = 1'b1; mret_i = 1'b1;
    push("mret_T",  1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0);
    push("mret_T1", 1'b1, 1'b1, 32'h300, 32'h88, 1'b0, 32'h0);
    push("mret_T2", 1'b1, 1'b0, 32'h0,   32'h0,  1'b1, 32'h3000);
    idle_exp("mret_T3");
    tick(); quiet();
    repeat (3) tick();

    // ebreak beats a simultaneous external interrupt; epc ignores the jump
    mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h200; inst_addr_i = 32'h5000;
    inst_valid_i = 1'b1; ebreak_i = 1'b1; int_flag_i = 8'h02;
    jump_flag_i = 1'b1; jump_addr_i = 32'h40;
    trap_exp("ebreak", 32'h5000, 32'h80, 32'd3, 32'h200);
    tick(); quiet();
    repeat (5) tick();

    // external interrupt alone with a taken jump: epc = jump target
    inst_valid_i = 1'b1; int_flag_i = 8'h02; jump_flag_i = 1'b1; jump_addr_i = 32'h40;
    trap_exp("ext_jmp", 32'h40, 32'h80, 32'h8000_000B, 32'h200);
    tick(); quiet();
    repeat (5) tick();

    // globally disabled: no action
    mstatus_i = 32'h0; inst_valid_i = 1'b1; int_flag_i = 8'h02; inst_addr_i = 32'hFFFF_FFFC;
    idle_exp("mie_off0"); idle_exp("mie_off1");
    tick(); tick();
    // enable: trap taken, pc+4 wraps to 0
    mstatus_i = 32'h8;
    trap_exp("ext_wrap", 32'h0, 32'h80, 32'h8000_000B, 32'h200);
    tick(); quiet();
    repeat (5) tick();

    // timer request with its mie bit clear, and ecall with no valid instruction
    mie_i = 32'h800; inst_valid_i = 1'b1; int_flag_i = 8'h01;
    idle_exp("mtie_off"); tick(); quiet();
    ecall_i = 1'b1;
    idle_exp("no_valid"); tick(); quiet();

    // reset during W_MSTATUS: no mcause write
    mie_i = 32'h80; inst_addr_i = 32'h2000; inst_valid_i = 1'b1; int_flag_i = 8'h01;
    push("rst_mid_T",  1'b1, 1'b0, 32'h0,   32'h0,     1'b0, 32'h0);
    push("rst_mid_T1", 1'b1, 1'b1, 32'h341, 32'h2004,  1'b0, 32'h0);
    tick(); quiet();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", "we", {31'b0, csr_we_o}, 32'h0);
    idle_exp("rst_mid_T2"); tick();
    rst_n = 1'b1;
    idle_exp("rst_rel0"); idle_exp("rst_rel1"); idle_exp("rst_rel2");
    repeat (3) tick();

    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
